dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller: byte/half/word loads and stores with
// lane masking, sign/zero extension, fault detection and self-initialisation.
module dmem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int INIT_WORDS  = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int BYTES     = DATA_W / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   init_idx_reg, init_idx_next;
    logic [3:0]         wait_cnt_reg, wait_cnt_next;

    logic               we_reg;
    logic [1:0]         size_reg;
    logic               unsigned_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic               err_reg;
    logic               load_reg;

    logic               accept;
    logic               exit_access;
    logic               init_we;

    logic [ADDR_W-1:0]  word_addr;
    logic [IDX_W-1:0]   mem_idx;
    logic [IDX_W-1:0]   wr_idx;
    int                 lane_i;
    int                 nbytes;
    int                 nbits;
    logic               fault;
    logic [BYTES-1:0]   be;
    logic [BYTES-1:0]   lane_we;
    logic               rd_en;
    logic [DATA_W-1:0]  init_val;
    logic [DATA_W-1:0]  wdata_sh;
    logic [DATA_W-1:0]  wr_word;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  rd_sh;
    logic [DATA_W-1:0]  load_ext;
    logic               msb;
    logic               sign_bit;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        init_idx_next = init_idx_reg;
        wait_cnt_next = wait_cnt_reg;
        accept        = 1'b0;
        exit_access   = 1'b0;
        init_we       = 1'b0;
        case (state_reg)
            INIT: begin
                init_we = 1'b1;
                if (init_idx_reg == IDX_W'(DEPTH - 1)) begin
                    state_next    = IDLE;
                    init_idx_next = '0;
                end else begin
                    init_idx_next = init_idx_reg + 1'b1;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    accept        = 1'b1;
                    wait_cnt_next = '0;
                    state_next    = ACCESS;
                end
            end
            ACCESS: begin
                if (wait_cnt_reg == 4'(WAIT_STATES)) begin
                    exit_access = 1'b1;
                    state_next  = RESP;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= INIT;
            init_idx_reg <= '0;
            wait_cnt_reg <= '0;
            we_reg       <= 1'b0;
            size_reg     <= '0;
            unsigned_reg <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            err_reg      <= 1'b0;
            load_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            init_idx_reg <= init_idx_next;
            wait_cnt_reg <= wait_cnt_next;
            if (accept) begin
                we_reg       <= req_we;
                size_reg     <= req_size;
                unsigned_reg <= req_unsigned;
                addr_reg     <= req_addr;
                wdata_reg    <= req_wdata;
            end
            if (exit_access) begin
                err_reg  <= fault;
                load_reg <= !we_reg && !fault;
            end
        end
    end

    // ------------------------------------------------------------------
    // Address decode and fault detection on the captured request
    // ------------------------------------------------------------------
    always_comb begin
        word_addr = addr_reg >> LANE_BITS;
        mem_idx   = word_addr[IDX_W-1:0];
        lane_i    = int'(addr_reg & ADDR_W'(BYTES - 1));
        nbytes    = 1 << size_reg;
        nbits     = 8 * nbytes;
        fault     = (size_reg == 2'b11) || (nbytes > BYTES) ||
                    ((lane_i & (nbytes - 1)) != 0) ||
                    (word_addr >= ADDR_W'(DEPTH));
        for (int b = 0; b < BYTES; b++) begin
            be[b] = (b >= lane_i) && (b < lane_i + nbytes);
        end
    end

    // ------------------------------------------------------------------
    // Write/read port control; reset suppresses any pending write
    // ------------------------------------------------------------------
    always_comb begin
        init_val = (int'(init_idx_reg) < INIT_WORDS) ? DATA_W'(init_idx_reg) : '0;
        wdata_sh = wdata_reg << (8 * lane_i);
        wr_word  = init_we ? init_val : wdata_sh;
        wr_idx   = init_we ? init_idx_reg : mem_idx;
        lane_we  = '0;
        if (!reset) begin
            if (init_we) begin
                lane_we = '1;
            end else if (exit_access && we_reg && !fault) begin
                lane_we = be;
            end
        end
        rd_en = !reset && exit_access && !we_reg && !fault;
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd;
            always_ff @(posedge clk) begin
                if (lane_we[gi]) begin
                    lane_mem[wr_idx] <= wr_word[gi*8 +: 8];
                end
                if (rd_en) begin
                    lane_rd <= lane_mem[mem_idx];
                end
            end
            assign rd_word[gi*8 +: 8] = lane_rd;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load alignment and extension; inputs are stable throughout RESP
    // ------------------------------------------------------------------
    always_comb begin
        rd_sh = rd_word >> (8 * lane_i);
        msb   = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == nbits - 1) begin
                msb = rd_sh[i];
            end
        end
        sign_bit = !unsigned_reg && msb;
        for (int i = 0; i < DATA_W; i++) begin
            load_ext[i] = (i < nbits) ? rd_sh[i] : sign_bit;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = (state_reg == RESP) && err_reg;
    assign rsp_rdata = ((state_reg == RESP) && load_reg) ? load_ext : '0;
    assign init_done = (state_reg != INIT);

endmodule
